// File: rtl/clock_pkg.sv
// -----------------------------------------------------------------------------
// clock_pkg
// Shared definitions for the HH:MM alarm clock controller:
//   - controller state encoding (also driven out on the 'mode' debug port)
//   - field focus encoding
//   - decoded, prioritised button type and the priority encoder
//   - bit positions of each BCD digit inside the 13-bit HH:MM word
//     {hr_tens[1:0], hr_units[3:0], min_tens[2:0], min_units[3:0]}
// -----------------------------------------------------------------------------
package clock_pkg;

  typedef enum logic [2:0] {
    ST_RUN       = 3'd0,
    ST_SET_TIME  = 3'd1,
    ST_SET_ALARM = 3'd2,
    ST_RING      = 3'd3
  } state_e;

  typedef enum logic {
    FOCUS_MIN = 1'b0,
    FOCUS_HR  = 1'b1
  } focus_e;

  // Only one button is acted on per cycle; this is the winner.
  typedef enum logic [2:0] {
    BTN_NONE = 3'd0,
    BTN_C    = 3'd1,
    BTN_L    = 3'd2,
    BTN_R    = 3'd3,
    BTN_U    = 3'd4,
    BTN_D    = 3'd5
  } btn_e;

  // Digit slice positions within the HH:MM BCD word.
  localparam int HR_T_MSB  = 12;
  localparam int HR_T_LSB  = 11;
  localparam int HR_U_MSB  = 10;
  localparam int HR_U_LSB  = 7;
  localparam int MIN_T_MSB = 6;
  localparam int MIN_T_LSB = 4;
  localparam int MIN_U_MSB = 3;
  localparam int MIN_U_LSB = 0;

  // Priority: centre > left > right > up > down.
  function automatic btn_e pick_button(input logic c, input logic l,
                                       input logic r, input logic u,
                                       input logic d);
    if (c)      return BTN_C;
    else if (l) return BTN_L;
    else if (r) return BTN_R;
    else if (u) return BTN_U;
    else if (d) return BTN_D;
    else        return BTN_NONE;
  endfunction

endpackage

// File: rtl/bcd_hhmm_adjust.sv
// -----------------------------------------------------------------------------
// bcd_hhmm_adjust
// Combinational one-step adjust of a packed BCD HH:MM value.
//   hhmm   : input time/alarm word
//   field  : FOCUS_MIN steps minutes, FOCUS_HR steps hours
//   up     : 1 = increment, 0 = decrement
//   result : adjusted word; minutes wrap 59<->00 and hours wrap 23<->00.
//            A minute wrap never carries into the hours.
// -----------------------------------------------------------------------------
module bcd_hhmm_adjust
  import clock_pkg::*;
(
  input  logic [12:0] hhmm,
  input  focus_e      field,
  input  logic        up,
  output logic [12:0] result
);

  logic [1:0] hr_t,  nhr_t;
  logic [3:0] hr_u,  nhr_u;
  logic [2:0] min_t, nmin_t;
  logic [3:0] min_u, nmin_u;

  assign hr_t  = hhmm[HR_T_MSB:HR_T_LSB];
  assign hr_u  = hhmm[HR_U_MSB:HR_U_LSB];
  assign min_t = hhmm[MIN_T_MSB:MIN_T_LSB];
  assign min_u = hhmm[MIN_U_MSB:MIN_U_LSB];

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    nhr_t  = hr_t;
    nhr_u  = hr_u;
    nmin_t = min_t;
    nmin_u = min_u;
    if (field == FOCUS_MIN) begin
      if (up) begin
        if (min_u == 4'd9) begin
          nmin_u = 4'd0;
          nmin_t = (min_t == 3'd5) ? 3'd0 : min_t + 3'd1;
        end else begin
          nmin_u = min_u + 4'd1;
        end
      end else begin
        if (min_u == 4'd0) begin
          nmin_u = 4'd9;
          nmin_t = (min_t == 3'd0) ? 3'd5 : min_t - 3'd1;
        end else begin
          nmin_u = min_u - 4'd1;
        end
      end
    end else begin
      if (up) begin
        if (hr_t == 2'd2 && hr_u == 4'd3) begin
          nhr_t = 2'd0;
          nhr_u = 4'd0;
        end else if (hr_u == 4'd9) begin
          nhr_u = 4'd0;
          nhr_t = hr_t + 2'd1;
        end else begin
          nhr_u = hr_u + 4'd1;
        end
      end else begin
        if (hr_t == 2'd0 && hr_u == 4'd0) begin
          nhr_t = 2'd2;
          nhr_u = 4'd3;
        end else if (hr_u == 4'd0) begin
          nhr_u = 4'd9;
          nhr_t = hr_t - 2'd1;
        end else begin
          nhr_u = hr_u - 4'd1;
        end
      end
    end
  end

  assign result = {nhr_t, nhr_u, nmin_t, nmin_u};

endmodule

// File: rtl/alarm_clock_ctrl.sv
// -----------------------------------------------------------------------------
// alarm_clock_ctrl
// Mode and alarm controller for an HH:MM alarm clock.
//   clk, rst         : system clock, asynchronous active-low reset
//   tick_1hz         : one-cycle pulse per second
//   btn_c/l/r/u/d    : debounced one-cycle button pulses
//   time_bcd         : live time from the time counter (packed BCD HH:MM)
//   time_run_en      : free-running enable to the time counter
//   time_up_down     : step direction to the time counter (1 = up)
//   min_step/hr_step : one-cycle step pulses to the time counter
//   alarm_bcd        : stored alarm time (packed BCD HH:MM)
//   disp_sel         : 0 = show time, 1 = show alarm
//   blank_hr/min     : blink blanking for the focused field
//   alarm_armed      : alarm enable (LED)
//   buzzer           : alarm sounding
//   mode             : current state encoding
// Every output is a register loaded from the next-state values, so a button
// pulse is decided in its own cycle and visible one cycle later.
// -----------------------------------------------------------------------------
module alarm_clock_ctrl
  import clock_pkg::*;
#(
  parameter int unsigned RING_SECS  = 60,
  parameter int unsigned BLINK_HALF = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        btn_c,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic [12:0] time_bcd,
  output logic        time_run_en,
  output logic        time_up_down,
  output logic        min_step,
  output logic        hr_step,
  output logic [12:0] alarm_bcd,
  output logic        disp_sel,
  output logic        blank_hr,
  output logic        blank_min,
  output logic        alarm_armed,
  output logic        buzzer,
  output logic [2:0]  mode
);

  localparam int BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);
  localparam logic [7:0]         RING_LAST  = 8'(RING_SECS - 1);

  state_e             state, nxt_state;
  focus_e             focus, nxt_focus;
  btn_e               btn;
  logic [7:0]         ring_cnt, nxt_ring_cnt;
  logic [BLINK_W-1:0] blink_cnt, nxt_blink_cnt;
  logic               phase, nxt_phase;
  logic               match_prev;
  logic [12:0]        nxt_alarm, alarm_adj;
  logic               nxt_armed, nxt_up_down, nxt_min_step, nxt_hr_step;
  logic               match, trigger, in_set, nxt_in_set, adj_up, blink_restart;

  assign btn     = pick_button(btn_c, btn_l, btn_r, btn_u, btn_d);
  assign match   = (time_bcd == alarm_bcd);
  // Rising edge of the compare: a match that was already present never fires.
  assign trigger = alarm_armed && match && !match_prev;
  assign in_set  = (state == ST_SET_TIME) || (state == ST_SET_ALARM);
  assign adj_up  = (btn == BTN_U);
  assign mode    = state;

  bcd_hhmm_adjust u_alarm_adjust (
    .hhmm   (alarm_bcd),
    .field  (focus),
    .up     (adj_up),
    .result (alarm_adj)
  );

  always_comb begin
    nxt_state     = state;
    nxt_focus     = focus;
    nxt_alarm     = alarm_bcd;
    nxt_armed     = alarm_armed;
    nxt_up_down   = time_up_down;
    nxt_min_step  = 1'b0;
    nxt_hr_step   = 1'b0;
    nxt_ring_cnt  = ring_cnt;
    nxt_blink_cnt = blink_cnt;
    nxt_phase     = phase;
    blink_restart = 1'b0;

    case (state)
      ST_RUN: begin
        if (trigger) begin
          nxt_state    = ST_RING;
          nxt_ring_cnt = 8'd0;
        end else if (btn == BTN_C) begin
          nxt_state = ST_SET_TIME;
          nxt_focus = FOCUS_MIN;
        end else if (btn == BTN_U) begin
          nxt_armed = ~alarm_armed;
        end
      end

      ST_SET_TIME: begin
        case (btn)
          BTN_C: begin
            nxt_state = ST_SET_ALARM;
            nxt_focus = FOCUS_MIN;
          end
          BTN_L: nxt_focus = FOCUS_HR;
          BTN_R: nxt_focus = FOCUS_MIN;
          BTN_U, BTN_D: begin
            nxt_up_down   = (btn == BTN_U);
            nxt_hr_step   = (focus == FOCUS_HR);
            nxt_min_step  = (focus == FOCUS_MIN);
            blink_restart = 1'b1;
          end
          default: ;
        endcase
      end

      ST_SET_ALARM: begin
        case (btn)
          BTN_C: begin
            nxt_state = ST_RUN;
            nxt_armed = 1'b1;
          end
          BTN_L: nxt_focus = FOCUS_HR;
          BTN_R: nxt_focus = FOCUS_MIN;
          BTN_U, BTN_D: begin
            nxt_alarm     = alarm_adj;
            blink_restart = 1'b1;
          end
          default: ;
        endcase
      end

      ST_RING: begin
        // A silencing press is consumed here and has no other effect.
        if (btn != BTN_NONE) begin
          nxt_state = ST_RUN;
        end else if (tick_1hz) begin
          if (ring_cnt == RING_LAST) nxt_state = ST_RUN;
          else                       nxt_ring_cnt = ring_cnt + 8'd1;
        end
      end

      default: nxt_state = ST_RUN;
    endcase

    // Blink runs only while staying in a set state; any change of state or
    // an up/down press restarts it in the visible phase.
    if (!in_set || (nxt_state != state) || blink_restart) begin
      nxt_blink_cnt = '0;
      nxt_phase     = 1'b0;
    end else if (tick_1hz) begin
      if (blink_cnt == BLINK_LAST) begin
        nxt_blink_cnt = '0;
        nxt_phase     = ~phase;
      end else begin
        nxt_blink_cnt = blink_cnt + 1'b1;
      end
    end

    // Direction only matters while adjusting time; elsewhere the counter counts up.
    if (nxt_state != ST_SET_TIME) nxt_up_down = 1'b1;
  end

  assign nxt_in_set = (nxt_state == ST_SET_TIME) || (nxt_state == ST_SET_ALARM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_RUN;
      focus        <= FOCUS_MIN;
      ring_cnt     <= 8'd0;
      blink_cnt    <= '0;
      phase        <= 1'b0;
      match_prev   <= 1'b0;
      alarm_bcd    <= 13'd0;
      alarm_armed  <= 1'b0;
      buzzer       <= 1'b0;
      time_run_en  <= 1'b1;
      time_up_down <= 1'b1;
      min_step     <= 1'b0;
      hr_step      <= 1'b0;
      disp_sel     <= 1'b0;
      blank_hr     <= 1'b0;
      blank_min    <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the values from before this edge.
      state        <= nxt_state;
      focus        <= nxt_focus;
      ring_cnt     <= nxt_ring_cnt;
      blink_cnt    <= nxt_blink_cnt;
      phase        <= nxt_phase;
      match_prev   <= match;
      alarm_bcd    <= nxt_alarm;
      alarm_armed  <= nxt_armed;
      buzzer       <= (nxt_state == ST_RING);
      time_run_en  <= (nxt_state != ST_SET_TIME);
      time_up_down <= nxt_up_down;
      min_step     <= nxt_min_step;
      hr_step      <= nxt_hr_step;
      disp_sel     <= (nxt_state == ST_SET_ALARM);
      blank_hr     <= nxt_in_set && (nxt_focus == FOCUS_HR)  && nxt_phase;
      blank_min    <= nxt_in_set && (nxt_focus == FOCUS_MIN) && nxt_phase;
    end
  end

endmodule
